// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared pipeline control types and stall patterns
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV_WAIT = 2'd1,
        FLUSH    = 2'd2
    } ctrl_state_e;

    localparam int STALL_W = 6;

    localparam int STALL_BIT_PC    = 0;
    localparam int STALL_BIT_IF_ID = 1;
    localparam int STALL_BIT_ID_EX = 2;
    localparam int STALL_BIT_EX_MEM = 3;
    localparam int STALL_BIT_MEM_WB = 4;
    localparam int STALL_BIT_WB    = 5;

    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

    // Stall vector for the free-running state: deepest requesting stage wins.
    function automatic logic [STALL_W-1:0] run_stall(input logic req_id,
                                                     input logic req_ex,
                                                     input logic req_mem);
        if (req_mem) begin
            return STALL_MEM;
        end else if (req_ex) begin
            return STALL_EX;
        end else if (req_id) begin
            return STALL_ID;
        end
        return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// rtl/pipe_ctrl_stall_watchdog.sv - saturating stall counter with sticky timeout flag
module pipe_ctrl_stall_watchdog #(
    parameter int STALL_TIMEOUT = 64
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_stalled,
    output logic o_timeout
);

    localparam logic [16:0] LIMIT = 17'(STALL_TIMEOUT);

    logic [15:0] cnt;
    logic [16:0] cnt_inc;

    assign cnt_inc = {1'b0, cnt} + 17'd1;

    // Count consecutive stalled cycles; the flag latches on the edge the count reaches the limit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt       <= 16'd0;
            o_timeout <= 1'b0;
        end else if (i_stalled) begin
            if (cnt != 16'hFFFF) begin
                cnt <= cnt_inc[15:0];
            end
            if (cnt_inc >= LIMIT) begin
                o_timeout <= 1'b1;
            end
        end else begin
            cnt <= 16'd0;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - five-stage pipeline stall, divide and flush sequencer
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int N_ADDR        = 32,
    parameter int STALL_TIMEOUT = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_stallreq_id,
    input  logic              i_stallreq_ex,
    input  logic              i_stallreq_mem,
    input  logic              i_div_start,
    input  logic              i_div_done,
    input  logic              i_flush_req,
    input  logic [N_ADDR-1:0] i_flush_pc,
    output logic [5:0]        o_stall,
    output logic              o_flush,
    output logic [N_ADDR-1:0] o_new_pc,
    output logic              o_new_pc_valid,
    output logic              o_div_abort,
    output logic              o_div_busy,
    output logic              o_timeout
);

    ctrl_state_e state_q;
    ctrl_state_e state_d;
    logic [5:0]  stall_d;
    logic        flush_take;

    // Requests landing in the flush cycle belong to stages being cleared, so they are dropped.
    assign flush_take = (state_q != FLUSH) && i_flush_req;

    // Next state and combinational stall vector.
    always_comb begin
        state_d = state_q;
        stall_d = STALL_NONE;
        case (state_q)
            RUN: begin
                stall_d = run_stall(i_stallreq_id, i_stallreq_ex | i_div_start, i_stallreq_mem);
                if (i_flush_req) begin
                    state_d = FLUSH;
                end else if (i_div_start) begin
                    state_d = DIV_WAIT;
                end
            end
            DIV_WAIT: begin
                stall_d = STALL_EX | (i_stallreq_mem ? STALL_MEM : STALL_NONE);
                if (i_flush_req) begin
                    state_d = FLUSH;
                end else if (i_div_done) begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Hold the stall vector low while reset is asserted so every output reads zero.
    assign o_stall    = i_rst ? STALL_NONE : stall_d;
    assign o_div_busy = (state_q == DIV_WAIT);

    // State register and the one-cycle registered flush/redirect/abort outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q        <= RUN;
            o_flush        <= 1'b0;
            o_new_pc_valid <= 1'b0;
            o_new_pc       <= '0;
            o_div_abort    <= 1'b0;
        end else begin
            state_q        <= state_d;
            o_flush        <= flush_take;
            o_new_pc_valid <= flush_take;
            if (flush_take) begin
                o_new_pc <= i_flush_pc;
            end
            // A divide finishing in the flush request cycle has nothing left to cancel.
            o_div_abort <= flush_take && (state_q == DIV_WAIT) && !i_div_done;
        end
    end

    pipe_ctrl_stall_watchdog #(
        .STALL_TIMEOUT(STALL_TIMEOUT)
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_stalled (|o_stall),
        .o_timeout (o_timeout)
    );

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage core. It generates the per-stage stall vector consumed by the pc, if_id, id_ex, ex_mem and mem_wb pipeline registers. It sequences multi-cycle divide operations against the shared divider and turns exception/branch flush requests into a one-cycle registered flush with a redirect PC. A stall watchdog flags a pipeline that stays stalled for too long.

## Interface
- N_ADDR, 32, width of instruction address
- STALL_TIMEOUT, 64, consecutive stalled cycles before o_timeout sets; legal range 2..2^16-1
- i_clk  in  1  pipeline clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_stallreq_id  in  1  load-use hazard from ID, combinational, same cycle
- i_stallreq_ex  in  1  single-cycle EX hazard (e.g. madd second pass)
- i_stallreq_mem  in  1  MEM stage wait (bus not ready)
- i_div_start  in  1  EX issues a divide to the shared divider
- i_div_done  in  1  divider result valid, one-cycle pulse
- i_flush_req  in  1  exception/redirect request from MEM
- i_flush_pc  in  N_ADDR  redirect target, sampled with i_flush_req
- o_stall  out  6  bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb, bit5 wb (always 0)
- o_flush  out  1  clear all pipeline registers to NOP values
- o_new_pc  out  N_ADDR  redirect address, valid with o_new_pc_valid
- o_new_pc_valid  out  1  pc register loads o_new_pc this cycle
- o_div_abort  out  1  one-cycle pulse that cancels the in-flight divide
- o_div_busy  out  1  controller is in DIV_WAIT
- o_timeout  out  1  sticky watchdog flag

## Operation
- States: RUN, DIV_WAIT, FLUSH. Reset state is RUN.
- RUN: o_stall is combinational from the requests. Priority is mem > ex > id.
  - mem request: 6'b011111
  - ex request: 6'b001111
  - id request: 6'b000111
  - no request: 0
  - i_div_start moves the controller to DIV_WAIT. In the start cycle o_stall = 6'b001111.
- DIV_WAIT: o_stall = 6'b001111, OR-ed with the mem-request pattern if i_stallreq_mem is asserted. Exits to RUN on the cycle after i_div_done. In the done cycle o_stall is still 6'b001111, so EX captures the result.
- FLUSH: lasts exactly one cycle.
  - o_flush = 1, o_stall = 0, o_new_pc_valid = 1.
  - o_new_pc holds i_flush_pc registered from the request cycle.
  - Next state is always RUN. Requests arriving in FLUSH are ignored, because their stages are being cleared.
- i_flush_req has the highest priority in RUN and in DIV_WAIT.
  - From DIV_WAIT, o_div_abort pulses in the FLUSH cycle. The exception is i_div_done in the same cycle as i_flush_req: the divide is already complete, so there is no abort.
  - i_flush_req together with i_div_start in RUN: the flush wins and DIV_WAIT is not entered.
- Watchdog:
  - A 16-bit counter increments each cycle that o_stall is nonzero. It clears on any cycle with o_stall == 0.
  - o_timeout sets when the counter reaches STALL_TIMEOUT and stays set until reset.
  - The counter saturates and does not wrap.
  - Only reset clears o_timeout.

## Timing
- Reset (async assert, sync release) values:
  - state = RUN
  - o_stall = 0, o_flush = 0
  - o_new_pc = 0, o_new_pc_valid = 0
  - o_div_abort = 0, o_div_busy = 0
  - o_timeout = 0
  - counter = 0
- Stall latency: 0 cycles in RUN (request to o_stall in the same cycle); DIV_WAIT stall comes from the state register.
- Flush latency: i_flush_req in cycle n gives o_flush, o_new_pc_valid and o_new_pc in cycle n+1, for one cycle only.
- o_div_busy = 1 exactly while state == DIV_WAIT.
- Divide of k cycles (i_div_start in cycle n, i_div_done in cycle n+k): stall is asserted for cycles n..n+k, and the controller is in RUN at n+k+1.
- Reset asserted mid-DIV_WAIT or mid-FLUSH returns to RUN immediately. No abort pulse is generated.

## Structure
- Shared package pipe_ctrl_pkg:
  - state enum ctrl_state_e {RUN, DIV_WAIT, FLUSH}
  - stall pattern constants STALL_NONE, STALL_ID, STALL_EX, STALL_MEM
  - stall bit index constants
  - The package is also used by the pipeline registers.
- One sub-module is natural: stall_watchdog (counter, saturation, sticky flag), parameterised by STALL_TIMEOUT.
- Everything else sits in pipe_ctrl: a next-state block plus registered outputs for o_flush, o_new_pc, o_new_pc_valid and o_div_abort.

## Test plan
- Priority: i_stallreq_id=1 and i_stallreq_mem=1 together in RUN -> o_stall = 6'b011111 in the same cycle; with id alone -> 6'b000111.
- Divide: i_div_start at cycle 10, i_div_done at cycle 17 -> o_stall = 6'b001111 for cycles 10..17, o_div_busy for 11..17, o_stall = 0 at 18.
- Flush: i_flush_req=1 with i_flush_pc=32'h0000_0180 at cycle 5 -> at cycle 6 o_flush=1, o_new_pc_valid=1, o_new_pc=32'h180, o_stall=0; cycle 7 all deasserted.
- Flush during divide: i_flush_req at cycle 3 of DIV_WAIT -> o_div_abort=1 and o_flush=1 next cycle, then RUN. A flush in the same cycle as i_div_done -> o_flush=1 but o_div_abort=0.
- Watchdog: STALL_TIMEOUT=8, i_stallreq_mem held high -> o_timeout rises after the 8th stalled cycle and stays high after the request drops. A 7-cycle stall followed by one free cycle -> no timeout.
- Reset mid-DIV_WAIT: assert i_rst asynchronously -> all outputs 0 immediately; after release, state is RUN and o_stall follows the request inputs.
